// File: rtl/k423_pkg.sv
// k423 core shared types: fetch-queue entry layout and instruction size.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

package k423_pkg;

   localparam int unsigned INST_BYTES = 4;

   typedef struct packed {
      logic [`CORE_ADDR_W-1:0] pc;
      logic [`CORE_INST_W-1:0] inst;
      logic                    prd_tkn;
      logic [`CORE_ADDR_W-1:0] prd_pc;
      logic [1:0]              prd_sat_cnt;
      logic                    filled;
   } fq_entry_t;

endpackage

// File: rtl/k423_if_fetch_queue.sv
// k423 fetch queue: circular buffer with alloc/fill/head pointers, one extra
// pointer bit to tell full from empty.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

module k423_if_fetch_queue
   import k423_pkg::*;
#(
   parameter int unsigned FQ_DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      alloc_i,
   input  logic [`CORE_ADDR_W-1:0]   alloc_pc_i,
   input  logic                      alloc_prd_tkn_i,
   input  logic [`CORE_ADDR_W-1:0]   alloc_prd_pc_i,
   input  logic [1:0]                alloc_prd_sat_cnt_i,
   input  logic                      fill_i,
   input  logic [`CORE_INST_W-1:0]   fill_inst_i,
   input  logic                      deq_i,
   output fq_entry_t                 head_o,
   output logic [$clog2(FQ_DEPTH):0] count_o,
   output logic [$clog2(FQ_DEPTH):0] unfilled_o
);

   localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
   typedef logic [PTR_W:0] ptr_t;

   ptr_t      alloc_ptr_q;
   ptr_t      fill_ptr_q;
   ptr_t      head_ptr_q;
   fq_entry_t mem_q [FQ_DEPTH];
   logic      fill_consumed;

   // A fill that lands on the head while it is dequeued was bypassed to ID.
   assign fill_consumed = deq_i && (fill_ptr_q == head_ptr_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
      end else if (flush_i) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
      end else begin
         if (alloc_i) alloc_ptr_q <= alloc_ptr_q + ptr_t'(1);
         if (fill_i)  fill_ptr_q  <= fill_ptr_q + ptr_t'(1);
         if (deq_i)   head_ptr_q  <= head_ptr_q + ptr_t'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (alloc_i) begin
         mem_q[alloc_ptr_q[PTR_W-1:0]].pc          <= alloc_pc_i;
         mem_q[alloc_ptr_q[PTR_W-1:0]].prd_tkn     <= alloc_prd_tkn_i;
         mem_q[alloc_ptr_q[PTR_W-1:0]].prd_pc      <= alloc_prd_pc_i;
         mem_q[alloc_ptr_q[PTR_W-1:0]].prd_sat_cnt <= alloc_prd_sat_cnt_i;
         mem_q[alloc_ptr_q[PTR_W-1:0]].filled      <= 1'b0;
      end
      if (fill_i && !fill_consumed) begin
         mem_q[fill_ptr_q[PTR_W-1:0]].inst   <= fill_inst_i;
         mem_q[fill_ptr_q[PTR_W-1:0]].filled <= 1'b1;
      end
   end

   assign head_o     = mem_q[head_ptr_q[PTR_W-1:0]];
   assign count_o    = alloc_ptr_q - head_ptr_q;
   assign unfilled_o = alloc_ptr_q - fill_ptr_q;

endmodule

// File: rtl/k423_if_fetch.sv
// k423 instruction-fetch stage: PC generation, in-order imem issue, fetch queue
// toward ID and stale-response dropping on redirect. Optional K423_IF_FQ_BYPASS_EN
// forwards a response that fills the head entry straight to ID in the same cycle.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

module k423_if_fetch
   import k423_pkg::*;
#(
   parameter logic [`CORE_ADDR_W-1:0] RST_PC   = 32'h8000_0000,
   parameter int unsigned             FQ_DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    pcu_redirect_i,
   input  logic [`CORE_ADDR_W-1:0] pcu_redirect_pc_i,
   input  logic                    pcu_stall_if_i,
   output logic [`CORE_ADDR_W-1:0] bpu_pc_o,
   input  logic                    bpu_prd_tkn_i,
   input  logic [`CORE_ADDR_W-1:0] bpu_prd_pc_i,
   input  logic [1:0]              bpu_prd_sat_cnt_i,
   output logic                    imem_req_vld_o,
   input  logic                    imem_req_rdy_i,
   output logic [`CORE_ADDR_W-1:0] imem_req_addr_o,
   input  logic                    imem_rsp_vld_i,
   input  logic [`CORE_INST_W-1:0] imem_rsp_data_i,
   output logic                    if_stage_vld_o,
   input  logic                    id_stage_rdy_i,
   output logic [`CORE_ADDR_W-1:0] if_pc_o,
   output logic [`CORE_INST_W-1:0] if_inst_o,
   output logic                    if_bpu_prd_tkn_o,
   output logic [`CORE_ADDR_W-1:0] if_bpu_prd_pc_o,
   output logic [1:0]              if_bpu_prd_sat_cnt_o
);

   localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_L = FQ_DEPTH[CNT_W:0];

   logic [`CORE_ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]        drop_cnt_q;
   logic [CNT_W-1:0]        drop_cnt_d;
   logic [CNT_W-1:0]        fq_count;
   logic [CNT_W-1:0]        fq_unfilled;
   logic [CNT_W:0]          occupancy;
   fq_entry_t               head;
   logic                    head_alloc;
   logic                    req_fire;
   logic                    rsp_fill;
   logic                    rsp_drop;
   logic                    bypass;
   logic                    out_vld;
   logic                    deq;
   logic [`CORE_INST_W-1:0] out_inst;

   // Responses still owed to dropped requests occupy slots like live entries.
   assign occupancy      = {1'b0, fq_count} + {1'b0, drop_cnt_q};
   assign imem_req_vld_o = !rst_i && !pcu_stall_if_i && !pcu_redirect_i && (occupancy < DEPTH_L);
   assign imem_req_addr_o = pc_q;
   assign bpu_pc_o        = pc_q;
   assign req_fire        = imem_req_vld_o && imem_req_rdy_i;

   assign rsp_fill   = imem_rsp_vld_i && (drop_cnt_q == '0) && !pcu_redirect_i;
   assign rsp_drop   = imem_rsp_vld_i && (drop_cnt_q != '0);
   assign head_alloc = (fq_count != '0);

`ifdef K423_IF_FQ_BYPASS_EN
   assign bypass = head_alloc && !head.filled && rsp_fill;
`else
   assign bypass = 1'b0;
`endif

   assign out_vld  = !pcu_redirect_i && ((head_alloc && head.filled) || bypass);
   assign out_inst = bypass ? imem_rsp_data_i : head.inst;
   assign deq      = out_vld && id_stage_rdy_i;

   assign if_stage_vld_o       = out_vld;
   assign if_pc_o              = out_vld ? head.pc : '0;
   assign if_inst_o            = out_vld ? out_inst : '0;
   assign if_bpu_prd_tkn_o     = out_vld && head.prd_tkn;
   assign if_bpu_prd_pc_o      = out_vld ? head.prd_pc : '0;
   assign if_bpu_prd_sat_cnt_o = out_vld ? head.prd_sat_cnt : 2'b00;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q <= RST_PC;
      end else if (pcu_redirect_i) begin
         pc_q <= pcu_redirect_pc_i;
      end else if (req_fire) begin
         pc_q <= bpu_prd_tkn_i ? bpu_prd_pc_i : pc_q + `CORE_ADDR_W'(INST_BYTES);
      end
   end

   // NOTE: drop_cnt_d gets its default first so no path through this block infers a latch.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (pcu_redirect_i) begin
         // Every unfilled entry becomes a response to discard; one arriving now is already gone.
         drop_cnt_d = drop_cnt_q + fq_unfilled - CNT_W'(imem_rsp_vld_i);
      end else if (rsp_drop) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(imem_rsp_vld_i && (drop_cnt_q == '0) && (fq_unfilled == '0)));
      end
   end

   k423_if_fetch_queue #(
      .FQ_DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .flush_i             (pcu_redirect_i),
      .alloc_i             (req_fire),
      .alloc_pc_i          (pc_q),
      .alloc_prd_tkn_i     (bpu_prd_tkn_i),
      .alloc_prd_pc_i      (bpu_prd_pc_i),
      .alloc_prd_sat_cnt_i (bpu_prd_sat_cnt_i),
      .fill_i              (rsp_fill),
      .fill_inst_i         (imem_rsp_data_i),
      .deq_i               (deq),
      .head_o              (head),
      .count_o             (fq_count),
      .unfilled_o          (fq_unfilled)
   );

endmodule

// File: tb/tb_k423_if_fetch.sv
// Directed bench for k423_if_fetch: in-order imem model with programmable latency,
// address-derived instruction words ({addr[15:0], 16'h1234}) and a one-PC taken BPU.
module tb_k423_if_fetch;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        pcu_redirect_i = 1'b0;
   logic [31:0] pcu_redirect_pc_i = '0;
   logic        pcu_stall_if_i = 1'b0;
   logic [31:0] bpu_pc_o;
   logic        bpu_prd_tkn_i;
   logic [31:0] bpu_prd_pc_i;
   logic [1:0]  bpu_prd_sat_cnt_i;
   logic        imem_req_vld_o;
   logic        imem_req_rdy_i = 1'b1;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_vld_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        if_stage_vld_o;
   logic        id_stage_rdy_i = 1'b1;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_bpu_prd_tkn_o;
   logic [31:0] if_bpu_prd_pc_o;
   logic [1:0]  if_bpu_prd_sat_cnt_o;

   always #5 clk_i = ~clk_i;

   k423_if_fetch dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .pcu_redirect_i       (pcu_redirect_i),
      .pcu_redirect_pc_i    (pcu_redirect_pc_i),
      .pcu_stall_if_i       (pcu_stall_if_i),
      .bpu_pc_o             (bpu_pc_o),
      .bpu_prd_tkn_i        (bpu_prd_tkn_i),
      .bpu_prd_pc_i         (bpu_prd_pc_i),
      .bpu_prd_sat_cnt_i    (bpu_prd_sat_cnt_i),
      .imem_req_vld_o       (imem_req_vld_o),
      .imem_req_rdy_i       (imem_req_rdy_i),
      .imem_req_addr_o      (imem_req_addr_o),
      .imem_rsp_vld_i       (imem_rsp_vld_i),
      .imem_rsp_data_i      (imem_rsp_data_i),
      .if_stage_vld_o       (if_stage_vld_o),
      .id_stage_rdy_i       (id_stage_rdy_i),
      .if_pc_o              (if_pc_o),
      .if_inst_o            (if_inst_o),
      .if_bpu_prd_tkn_o     (if_bpu_prd_tkn_o),
      .if_bpu_prd_pc_o      (if_bpu_prd_pc_o),
      .if_bpu_prd_sat_cnt_o (if_bpu_prd_sat_cnt_o)
   );

   // BPU model: predicts taken only at tkn_pc.
   logic        tkn_en = 1'b0;
   logic [31:0] tkn_pc = '0;
   logic [31:0] tkn_tgt = '0;
   assign bpu_prd_tkn_i     = tkn_en && (bpu_pc_o == tkn_pc);
   assign bpu_prd_pc_i      = bpu_prd_tkn_i ? tkn_tgt : 32'h0;
   assign bpu_prd_sat_cnt_i = bpu_prd_tkn_i ? 2'b11 : 2'b01;

   // imem model: in-order, response sampled by the DUT lat edges after acceptance.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend_q[$];
   int    cyc = 0;
   int    lat = 1;
   int    acc_cnt = 0;

   always @(posedge clk_i) begin
      cyc++;
      if (!rst_i && imem_req_vld_o && imem_req_rdy_i) begin
         pend_q.push_back('{imem_req_addr_o, cyc + lat});
         acc_cnt++;
      end
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         pend_q.delete();
         imem_rsp_vld_i  = 1'b0;
         imem_rsp_data_i = '0;
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
         imem_rsp_vld_i  = 1'b1;
         imem_rsp_data_i = {pend_q[0].addr[15:0], 16'h1234};
         void'(pend_q.pop_front());
      end else begin
         imem_rsp_vld_i  = 1'b0;
         imem_rsp_data_i = '0;
      end
   end

   int checks = 0;
   int errors = 0;
   int acc_base = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic wait_vld(input string tag, input int budget);
      int i = 0;
      while (!if_stage_vld_o && i < budget) begin
         step();
         i++;
      end
      check(tag, if_stage_vld_o, 1);
   endtask

   initial begin
      // Reset state
      #1 rst_i = 1'b1;
      #2;
      check("rst_vld", if_stage_vld_o, 0);
      check("rst_req_vld", imem_req_vld_o, 0);
      check("rst_req_addr", imem_req_addr_o, 32'h8000_0000);
      check("rst_bpu_pc", bpu_pc_o, 32'h8000_0000);
      check("rst_if_pc", if_pc_o, 0);
      check("rst_if_inst", if_inst_o, 0);
      check("rst_if_sat", if_bpu_prd_sat_cnt_o, 0);
      step();
      rst_i = 1'b0;
      #1;
      check("first_req_vld", imem_req_vld_o, 1);
      check("first_req_addr", imem_req_addr_o, 32'h8000_0000);

      // Sequential fetch, 1-cycle imem, ID always ready
      step();
      check("seq_addr1", imem_req_addr_o, 32'h8000_0004);
      check("seq_vld_lat", if_stage_vld_o, 0);
      step();
      check("seq_addr2", imem_req_addr_o, 32'h8000_0008);
      check("seq_vld0", if_stage_vld_o, 1);
      check("seq_pc0", if_pc_o, 32'h8000_0000);
      check("seq_inst0", if_inst_o, 32'h0000_1234);
      step();
      check("seq_vld1", if_stage_vld_o, 1);
      check("seq_pc1", if_pc_o, 32'h8000_0004);
      check("seq_inst1", if_inst_o, 32'h0004_1234);
      step();
      check("seq_pc2", if_pc_o, 32'h8000_0008);
      pcu_stall_if_i = 1'b1;
      step(4);
      check("drain_vld", if_stage_vld_o, 0);
      check("stall_req_vld", imem_req_vld_o, 0);
      check("stall_addr", imem_req_addr_o, 32'h8000_0010);

      // Redirect while stalled, then a taken prediction at 8000_0004
      pcu_redirect_i    = 1'b1;
      pcu_redirect_pc_i = 32'h8000_0000;
      step();
      pcu_redirect_i = 1'b0;
      check("redir_in_stall_pc", bpu_pc_o, 32'h8000_0000);
      tkn_en         = 1'b1;
      tkn_pc         = 32'h8000_0004;
      tkn_tgt        = 32'h8000_0100;
      pcu_stall_if_i = 1'b0;
      step();
      check("bpu_addr_a", imem_req_addr_o, 32'h8000_0004);
      step();
      check("bpu_addr_tgt", imem_req_addr_o, 32'h8000_0100);
      check("bpu_pc0", if_pc_o, 32'h8000_0000);
      check("bpu_tkn0", if_bpu_prd_tkn_o, 0);
      check("bpu_sat0", if_bpu_prd_sat_cnt_o, 2'b01);
      step();
      check("bpu_pc1", if_pc_o, 32'h8000_0004);
      check("bpu_tkn1", if_bpu_prd_tkn_o, 1);
      check("bpu_tgt1", if_bpu_prd_pc_o, 32'h8000_0100);
      check("bpu_sat1", if_bpu_prd_sat_cnt_o, 2'b11);
      step();
      check("bpu_pc2", if_pc_o, 32'h8000_0100);
      check("bpu_tkn2", if_bpu_prd_tkn_o, 0);
      pcu_stall_if_i = 1'b1;
      tkn_en         = 1'b0;
      step(5);
      check("bpu_drain", if_stage_vld_o, 0);

      // ID back-pressure: queue fills to FQ_DEPTH
      id_stage_rdy_i    = 1'b0;
      pcu_redirect_i    = 1'b1;
      pcu_redirect_pc_i = 32'h8000_0000;
      step();
      pcu_redirect_i = 1'b0;
      pcu_stall_if_i = 1'b0;
      acc_base       = acc_cnt;
      step(10);
      check("full_accepts", acc_cnt - acc_base, 4);
      check("full_req_vld", imem_req_vld_o, 0);
      check("full_head_vld", if_stage_vld_o, 1);
      check("full_head_pc", if_pc_o, 32'h8000_0000);
      check("full_head_inst", if_inst_o, 32'h0000_1234);
      pcu_stall_if_i = 1'b1;
      id_stage_rdy_i = 1'b1;
      step(6);
      check("full_drain", if_stage_vld_o, 0);

      // Redirect with 3 outstanding, 3-cycle latency
      lat               = 3;
      pcu_redirect_i    = 1'b1;
      pcu_redirect_pc_i = 32'h8000_1000;
      step();
      pcu_redirect_i = 1'b0;
      pcu_stall_if_i = 1'b0;
      id_stage_rdy_i = 1'b0;
      acc_base       = acc_cnt;
      step(3);
      check("drop_outstanding", acc_cnt - acc_base, 3);
      pcu_redirect_i    = 1'b1;
      pcu_redirect_pc_i = 32'h8000_2000;
      #1;
      check("redir_suppress", imem_req_vld_o, 0);
      step();
      pcu_redirect_i = 1'b0;
      wait_vld("drop_wait", 12);
      check("drop_first_pc", if_pc_o, 32'h8000_2000);
      check("drop_first_inst", if_inst_o, 32'h2000_1234);
      id_stage_rdy_i = 1'b1;
      step();
      check("drop_second_pc", if_pc_o, 32'h8000_2004);
      check("drop_second_inst", if_inst_o, 32'h2004_1234);
      pcu_stall_if_i = 1'b1;
      step(12);
      check("drop_drain", if_stage_vld_o, 0);
      lat = 1;

      // Request held without rdy while stall toggles
      pcu_redirect_i    = 1'b1;
      pcu_redirect_pc_i = 32'h8000_3000;
      step();
      pcu_redirect_i = 1'b0;
      imem_req_rdy_i = 1'b0;
      acc_base       = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         pcu_stall_if_i = i[0];
         step();
         check("hold_addr", imem_req_addr_o, 32'h8000_3000);
      end
      check("hold_no_accept", acc_cnt - acc_base, 0);
      check("hold_no_entry", if_stage_vld_o, 0);
      imem_req_rdy_i = 1'b1;
      pcu_stall_if_i = 1'b0;
      id_stage_rdy_i = 1'b0;
      step();
      pcu_stall_if_i = 1'b1;
      step();
      check("hold_head_vld", if_stage_vld_o, 1);
      check("hold_head_pc", if_pc_o, 32'h8000_3000);
      id_stage_rdy_i = 1'b1;
      step();
      check("hold_single_entry", if_stage_vld_o, 0);
      check("hold_one_accept", acc_cnt - acc_base, 1);
      check("hold_next_addr", imem_req_addr_o, 32'h8000_3004);

      // Asynchronous reset with 2 outstanding
      lat            = 3;
      pcu_stall_if_i = 1'b0;
      step(2);
      pcu_stall_if_i = 1'b1;
      rst_i          = 1'b1;
      #1;
      check("mid_rst_vld", if_stage_vld_o, 0);
      check("mid_rst_req_vld", imem_req_vld_o, 0);
      check("mid_rst_addr", imem_req_addr_o, 32'h8000_0000);
      check("mid_rst_if_pc", if_pc_o, 0);
      step(2);
      rst_i          = 1'b0;
      lat            = 1;
      pcu_stall_if_i = 1'b0;
      wait_vld("post_rst_wait", 10);
      check("post_rst_pc", if_pc_o, 32'h8000_0000);
      check("post_rst_inst", if_inst_o, 32'h0000_1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
